// File: rtl/dcache_fifo_bank.sv
// dcache_fifo_bank: bank of shift-style store FIFOs, searchable by dcache and drained round-robin to memory.
// Ports:
//   clock, reset                 clock; synchronous active-low reset
//   push_en/sel/index/tag/data   push request, target FIFO and entry fields
//   push_ready                   FIFO push_sel is not full (pre-cycle count)
//   FIFO, FIFO_valid, fifo_count all entries (slot 0 oldest), per-slot valid, occupancy
//   mem_valid/index/tag/data     drain entry offered to memory
//   mem_ready                    memory accepts the drain entry
module dcache_fifo_bank #(
    parameter int NUM_FIFO     = 8,
    parameter int FIFO_SIZE    = 8,
    parameter int NUM_SET_BITS = 3,
    parameter int NUM_TAG_BITS = 10,
    parameter int ENTRY_W      = NUM_SET_BITS + NUM_TAG_BITS + 64,
    localparam int SEL_W       = $clog2(NUM_FIFO),
    localparam int CNT_W       = $clog2(FIFO_SIZE + 1)
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic                                            push_en,
    input  logic [SEL_W-1:0]                                push_sel,
    input  logic [NUM_SET_BITS-1:0]                         push_index,
    input  logic [NUM_TAG_BITS-1:0]                         push_tag,
    input  logic [63:0]                                     push_data,
    output logic                                            push_ready,
    output logic [NUM_FIFO-1:0][FIFO_SIZE-1:0][ENTRY_W-1:0] FIFO,
    output logic [NUM_FIFO-1:0][FIFO_SIZE-1:0]              FIFO_valid,
    output logic [NUM_FIFO-1:0][CNT_W-1:0]                  fifo_count,
    output logic                                            mem_valid,
    output logic [NUM_SET_BITS-1:0]                         mem_index,
    output logic [NUM_TAG_BITS-1:0]                         mem_tag,
    output logic [63:0]                                     mem_data,
    input  logic                                            mem_ready
);
    localparam int SLOT_W = $clog2(FIFO_SIZE);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                             state;
    logic [SEL_W-1:0]                   sel, rr_ptr, next_sel, idx;
    logic                               found;
    logic [NUM_FIFO-1:0]                push_hit, pop_hit;
    logic [NUM_FIFO-1:0][SLOT_W-1:0]    wr_slot;
    logic [ENTRY_W-1:0]                 push_entry;

    assign push_entry = {push_index, push_tag, push_data};
    assign push_ready = fifo_count[push_sel] != CNT_W'(FIFO_SIZE);
    assign mem_valid  = state == SEND;
    // sel is latched while in SEND and pushes never touch slot 0 of a non-empty FIFO, so the offer is stable
    assign {mem_index, mem_tag, mem_data} = mem_valid ? FIFO[sel][0] : '0;

    always_comb begin
        for (int i = 0; i < NUM_FIFO; i++) begin
            pop_hit[i]  = mem_valid && mem_ready && sel == SEL_W'(i);
            push_hit[i] = push_en && push_ready && push_sel == SEL_W'(i);
            // with a simultaneous pop the entry lands one slot lower, after the shift
            wr_slot[i]  = SLOT_W'(fifo_count[i] - CNT_W'(pop_hit[i]));
            for (int j = 0; j < FIFO_SIZE; j++)
                FIFO_valid[i][j] = CNT_W'(j) < fifo_count[i];
        end
    end

    // first non-empty FIFO at or after rr_ptr, with wrap; descending loop so the nearest one wins
    always_comb begin
        next_sel = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = NUM_FIFO - 1; k >= 0; k--) begin
            idx = SEL_W'((int'(rr_ptr) + k) % NUM_FIFO);
            if (fifo_count[idx] != '0) begin
                next_sel = idx;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            FIFO       <= '0;
            fifo_count <= '0;
            state      <= IDLE;
            sel        <= '0;
            rr_ptr     <= '0;
        end else begin
            for (int i = 0; i < NUM_FIFO; i++) begin
                if (pop_hit[i]) begin
                    for (int j = 0; j < FIFO_SIZE - 1; j++)
                        FIFO[i][j] <= FIFO[i][j+1];
                    FIFO[i][FIFO_SIZE-1] <= '0;
                end
                if (push_hit[i])
                    FIFO[i][wr_slot[i]] <= push_entry;
                fifo_count[i] <= fifo_count[i] + CNT_W'(push_hit[i]) - CNT_W'(pop_hit[i]);
            end
            if (state == IDLE) begin
                if (found) begin
                    sel   <= next_sel;
                    state <= SEND;
                end
            end else if (mem_ready) begin
                rr_ptr <= SEL_W'((int'(sel) + 1) % NUM_FIFO);
                state  <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_dcache_fifo_bank.sv
// tb_dcache_fifo_bank: queue-model scoreboard bench for dcache_fifo_bank.
module tb_dcache_fifo_bank;
    localparam int NF = 8;
    localparam int FS = 8;
    localparam int EW = 77;

    typedef logic [EW-1:0] entry_t;

    logic                        clock = 1'b0;
    logic                        reset = 1'b0;
    logic                        push_en = 1'b0;
    logic [2:0]                  push_sel = '0;
    logic [2:0]                  push_index = '0;
    logic [9:0]                  push_tag = '0;
    logic [63:0]                 push_data = '0;
    logic                        push_ready;
    logic [NF-1:0][FS-1:0][EW-1:0] FIFO;
    logic [NF-1:0][FS-1:0]       FIFO_valid;
    logic [NF-1:0][3:0]          fifo_count;
    logic                        mem_valid;
    logic [2:0]                  mem_index;
    logic [9:0]                  mem_tag;
    logic [63:0]                 mem_data;
    logic                        mem_ready = 1'b0;

    dcache_fifo_bank dut (
        .clock(clock), .reset(reset),
        .push_en(push_en), .push_sel(push_sel), .push_index(push_index),
        .push_tag(push_tag), .push_data(push_data), .push_ready(push_ready),
        .FIFO(FIFO), .FIFO_valid(FIFO_valid), .fifo_count(fifo_count),
        .mem_valid(mem_valid), .mem_index(mem_index), .mem_tag(mem_tag),
        .mem_data(mem_data), .mem_ready(mem_ready)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // reference model: one queue per FIFO, drain offer and round-robin pointer
    entry_t mq [NF][$];
    entry_t exp_q [$];
    bit     msend = 0;
    bit     started = 0;
    int     msel = 0;
    int     mrr = 0;

    task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit accept;
        if (!reset) begin
            for (int i = 0; i < NF; i++) mq[i].delete();
            exp_q.delete();
            msend   = 0;
            mrr     = 0;
            started = 1;
        end else begin
            accept = push_en && mq[push_sel].size() < FS;
            if (!msend) begin
                for (int k = 0; k < NF; k++) begin
                    if (mq[(mrr + k) % NF].size() != 0) begin
                        msel  = (mrr + k) % NF;
                        msend = 1;
                        exp_q.push_back(mq[msel][0]);
                        break;
                    end
                end
            end else if (mem_ready) begin
                void'(mq[msel].pop_front());
                mrr   = (msel + 1) % NF;
                msend = 0;
            end
            if (accept) mq[push_sel].push_back({push_index, push_tag, push_data});
        end
    endtask

    task automatic monitor();
        logic [FS*EW-1:0] ev;
        logic [FS-1:0]    vv;
        for (int i = 0; i < NF; i++) begin
            ev = '0;
            vv = '0;
            for (int j = 0; j < mq[i].size(); j++) begin
                ev[j*EW +: EW] = mq[i][j];
                vv[j] = 1'b1;
            end
            check($sformatf("fifo%0d", i), FIFO[i], ev);
            check($sformatf("valid%0d", i), FIFO_valid[i], vv);
            check($sformatf("count%0d", i), fifo_count[i], mq[i].size());
        end
        check("push_ready", push_ready, mq[push_sel].size() != FS);
        check("mem_valid", mem_valid, msend);
        if (mem_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL mem_offer: got %0h expected none", {mem_index, mem_tag, mem_data});
            end else begin
                check("mem_entry", {mem_index, mem_tag, mem_data}, exp_q[0]);
                if (mem_ready && reset) void'(exp_q.pop_front());
            end
        end else begin
            check("mem_idle_zero", {mem_index, mem_tag, mem_data}, 0);
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    initial forever begin
        @(negedge clock);
        if (started) monitor();
    end

    task automatic step(input bit pe, input int ps, input logic [2:0] ix, input logic [9:0] tg,
                        input logic [63:0] d, input bit mr, input bit rs = 1'b1);
        push_en    = pe;
        push_sel   = 3'(ps);
        push_index = ix;
        push_tag   = tg;
        push_data  = d;
        mem_ready  = mr;
        reset      = rs;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [63:0] rd;
        repeat (2) step(1, 0, 3'b111, 10'h3FF, '1, 1, 0);
        check("reset_fifo", FIFO, 0);
        check("reset_valid", FIFO_valid, 0);
        check("reset_count", fifo_count, 0);
        check("reset_mem_valid", mem_valid, 0);

        for (int j = 0; j < 8; j++) step(1, 0, 3'b010, 10'(j), {{61{1'b1}}, 3'(j)}, 0);
        for (int j = 0; j < 8; j++) step(1, 1, 3'b110, 10'(8 + j), {{60{1'b1}}, 1'b0, 3'(j)}, 0);
        check("fifo1_slot1", FIFO[1][1], {3'b110, 10'd9, {60{1'b1}}, 4'b0001});
        check("full_count0", fifo_count[0], 8);
        check("full_count1", fifo_count[1], 8);
        push_en = 0; push_sel = 0; #1;
        check("ready_sel0", push_ready, 0);
        push_sel = 1; #1;
        check("ready_sel1", push_ready, 0);

        step(1, 0, 3'b010, 10'h3FF, 64'h0, 0);
        check("ninth_push_ignored", FIFO[0][7], {3'b010, 10'd7, {61{1'b1}}, 3'b111});

        repeat (5) begin
            step(0, 0, 0, 0, 0, 0);
            check("hold_valid", mem_valid, 1);
            check("hold_tag", mem_tag, 0);
        end
        step(0, 0, 0, 0, 0, 1);
        check("pop_head_tag", FIFO[0][0][73:64], 1);
        check("pop_count0", fifo_count[0], 7);
        step(0, 0, 0, 0, 0, 0);
        check("rr_next_tag", mem_tag, 8);
        // push to a full FIFO during its own pop is refused (pre-cycle push_ready)
        step(1, 1, 3'b001, 10'h155, 64'hDEAD, 1);
        check("full_pushpop_count", fifo_count[1], 7);
        check("full_pushpop_top", FIFO[1][7], 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 3'b101, 10'h2AA, 64'hCAFE, 1);
        check("pushpop_count0", fifo_count[0], 7);
        check("pushpop_slot6", FIFO[0][6], {3'b101, 10'h2AA, 64'hCAFE});

        for (int n = 0; n < 2000; n++) begin
            rd = {$urandom, $urandom};
            step($urandom_range(0, 2) != 0, $urandom_range(0, NF - 1), 3'($urandom),
                 10'($urandom), rd, $urandom_range(0, 3) == 0, $urandom_range(0, 299) != 0);
        end

        step(1, 3, 3'b011, 10'h123, 64'h1234, 0);
        step(0, 0, 0, 0, 0, 0);
        check("pre_reset_send", mem_valid, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        check("abort_mem_valid", mem_valid, 0);
        check("abort_count", fifo_count, 0);
        check("abort_fifo", FIFO, 0);
        step(0, 0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
